// File: rtl/dbg_slave_cmd_decoder_if.sv
// Command-path bundle between the tck-side shift logic (master) and the
// sysclk command decoder (slave).
interface dbg_slave_cmd_decoder_if #(
   parameter int SR_W  = 38,
   parameter int IR_W  = 2,
   parameter int N_CH  = 4,
   parameter int DEPTH = 4
);
   localparam int LVL_W = $clog2(DEPTH + 1);

   logic [SR_W-1:0]  sr;
   logic [IR_W-1:0]  ir_in;
   logic             vs_udr;
   logic             vs_uir;
   logic             cmd_ready;
   logic             ovf_clr;
   logic             cmd_valid;
   logic [SR_W-1:0]  jdo;
   logic [IR_W-1:0]  cmd_ir;
   logic [IR_W-1:0]  cur_ir;
   logic [N_CH-1:0]  take_action;
   logic [N_CH-1:0]  take_no_action;
   logic             bad_ir;
   logic             ovf_sticky;
   logic [LVL_W-1:0] fifo_level;
   logic             parity_err;

   modport master (
      output sr, ir_in, vs_udr, vs_uir, cmd_ready, ovf_clr,
      input  cmd_valid, jdo, cmd_ir, cur_ir, take_action, take_no_action,
             bad_ir, ovf_sticky, fifo_level, parity_err
   );

   modport slave (
      input  sr, ir_in, vs_udr, vs_uir, cmd_ready, ovf_clr,
      output cmd_valid, jdo, cmd_ir, cur_ir, take_action, take_no_action,
             bad_ir, ovf_sticky, fifo_level, parity_err
   );
endinterface

// File: rtl/dbg_slave_cmd_decoder.sv
// Sysclk-side debug-slave command decoder: syncs tck update strobes, queues {ir, sr}
// commands in a FIFO and emits per-channel action pulses. Optional DBG_SLAVE_CMD_PARITY_EN.
module dbg_slave_cmd_decoder #(
   parameter int SR_W        = 38,
   parameter int IR_W        = 2,
   parameter int N_CH        = 4,
   parameter int DEPTH       = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   dbg_slave_cmd_decoder_if.slave bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = $clog2(DEPTH + 1);
   localparam int ENT_W = IR_W + SR_W;
   localparam int ARM_W = $clog2(SYNC_STAGES + 1);

   logic [SYNC_STAGES-1:0] udr_sync_reg;
   logic [SYNC_STAGES-1:0] uir_sync_reg;
   logic                   udr_prev_reg;
   logic                   uir_prev_reg;
   logic [ARM_W-1:0]       arm_cnt_reg;
   logic                   armed;
   logic                   udr_s;
   logic                   uir_s;
   logic                   udr_edge;
   logic                   uir_edge;

   logic [ENT_W-1:0]       mem [DEPTH];
   logic [PTR_W-1:0]       wr_ptr_reg;
   logic [PTR_W-1:0]       rd_ptr_reg;
   logic [LVL_W-1:0]       level_reg;
   logic [LVL_W-1:0]       level_next;
   logic                   cmd_valid_reg;
   logic                   cmd_valid_next;
   logic                   full;
   logic                   pop;
   logic                   push;
   logic                   drop;
   logic                   par_ok;

   logic [ENT_W-1:0]       head;
   logic [IR_W-1:0]        head_ir;
   logic                   head_msb;
   logic [N_CH-1:0]        ch_hit;

   logic [SR_W-1:0]        jdo_reg;
   logic [IR_W-1:0]        cmd_ir_reg;
   logic [IR_W-1:0]        cur_ir_reg;
   logic [N_CH-1:0]        take_action_reg;
   logic [N_CH-1:0]        take_no_action_reg;
   logic                   bad_ir_reg;
   logic                   ovf_sticky_reg;

   assign udr_s = udr_sync_reg[SYNC_STAGES-1];
   assign uir_s = uir_sync_reg[SYNC_STAGES-1];
   assign armed = (arm_cnt_reg == ARM_W'(SYNC_STAGES));

   // Previous-sample flops are held at 1 until the chains have refilled after
   // reset, so a level that was already high at release never looks like an edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         udr_sync_reg <= '0;
         uir_sync_reg <= '0;
         udr_prev_reg <= 1'b1;
         uir_prev_reg <= 1'b1;
         arm_cnt_reg  <= '0;
      end else begin
         udr_sync_reg <= {udr_sync_reg[SYNC_STAGES-2:0], bus.vs_udr};
         uir_sync_reg <= {uir_sync_reg[SYNC_STAGES-2:0], bus.vs_uir};
         udr_prev_reg <= udr_s | ~armed;
         uir_prev_reg <= uir_s | ~armed;
         if (!armed) begin
            arm_cnt_reg <= arm_cnt_reg + ARM_W'(1);
         end
      end
   end

   assign udr_edge = udr_s & ~udr_prev_reg;
   assign uir_edge = uir_s & ~uir_prev_reg;

`ifdef DBG_SLAVE_CMD_PARITY_EN
   logic parity_err_reg;

   assign par_ok = ~(^bus.sr);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         parity_err_reg <= 1'b0;
      end else if (udr_edge && !par_ok) begin
         parity_err_reg <= 1'b1;
      end else if (bus.ovf_clr) begin
         parity_err_reg <= 1'b0;
      end
   end

   assign bus.parity_err = parity_err_reg;
`else
   assign par_ok         = 1'b1;
   assign bus.parity_err = 1'b0;
`endif

   assign full = (level_reg == LVL_W'(DEPTH));
   assign pop  = cmd_valid_reg & bus.cmd_ready;
   assign push = udr_edge & par_ok & (~full | pop);
   assign drop = udr_edge & par_ok & full & ~pop;

   // A fresh entry is presented one cycle after it lands; an emptying pop
   // drops cmd_valid immediately so an empty FIFO is never popped.
   always_comb begin
      level_next = level_reg;
      case ({push, pop})
         2'b10:   level_next = level_reg + LVL_W'(1);
         2'b01:   level_next = level_reg - LVL_W'(1);
         default: level_next = level_reg;
      endcase
      cmd_valid_next = (level_reg != '0) && (level_next != '0);
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_reg] <= {bus.ir_in, bus.sr};
      end
   end

   assign head     = mem[rd_ptr_reg];
   assign head_ir  = head[ENT_W-1:SR_W];
   assign head_msb = head[SR_W-1];

   generate
      for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
         assign ch_hit[gi] = (head_ir == IR_W'(gi));
      end
   endgenerate

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_reg         <= '0;
         rd_ptr_reg         <= '0;
         level_reg          <= '0;
         cmd_valid_reg      <= 1'b0;
         jdo_reg            <= '0;
         cmd_ir_reg         <= '0;
         cur_ir_reg         <= '0;
         take_action_reg    <= '0;
         take_no_action_reg <= '0;
         bad_ir_reg         <= 1'b0;
         ovf_sticky_reg     <= 1'b0;
      end else begin
         level_reg     <= level_next;
         cmd_valid_reg <= cmd_valid_next;
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            jdo_reg    <= head[SR_W-1:0];
            cmd_ir_reg <= head_ir;
         end
         take_action_reg    <= (pop &&  head_msb) ? ch_hit : '0;
         take_no_action_reg <= (pop && !head_msb) ? ch_hit : '0;
         bad_ir_reg         <= pop & ~(|ch_hit);
         if (uir_edge) begin
            cur_ir_reg <= bus.ir_in;
         end
         if (drop) begin
            ovf_sticky_reg <= 1'b1;
         end else if (bus.ovf_clr) begin
            ovf_sticky_reg <= 1'b0;
         end
      end
   end

   assign bus.cmd_valid      = cmd_valid_reg;
   assign bus.jdo            = jdo_reg;
   assign bus.cmd_ir         = cmd_ir_reg;
   assign bus.cur_ir         = cur_ir_reg;
   assign bus.take_action    = take_action_reg;
   assign bus.take_no_action = take_no_action_reg;
   assign bus.bad_ir         = bad_ir_reg;
   assign bus.ovf_sticky     = ovf_sticky_reg;
   assign bus.fifo_level     = level_reg;
endmodule

// File: tb/tb_dbg_slave_cmd_decoder.sv
// Directed bench for dbg_slave_cmd_decoder: a queue holds commands expected to be
// accepted; every pulse seen on the outputs is popped and checked against it.
module tb_dbg_slave_cmd_decoder;
   localparam int SR_W  = 38;
   localparam int IR_W  = 2;
   localparam int N_CH  = 4;
   localparam int DEPTH = 4;

   typedef struct packed {
      logic [IR_W-1:0] ir;
      logic [SR_W-1:0] sr;
   } ent_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   dbg_slave_cmd_decoder_if #(.SR_W(SR_W), .IR_W(IR_W), .N_CH(N_CH), .DEPTH(DEPTH)) bus0 ();
   dbg_slave_cmd_decoder_if #(.SR_W(SR_W), .IR_W(IR_W), .N_CH(3),    .DEPTH(DEPTH)) bus1 ();

   assign bus1.sr        = bus0.sr;
   assign bus1.ir_in     = bus0.ir_in;
   assign bus1.vs_udr    = bus0.vs_udr;
   assign bus1.vs_uir    = bus0.vs_uir;
   assign bus1.cmd_ready = bus0.cmd_ready;
   assign bus1.ovf_clr   = bus0.ovf_clr;

   dbg_slave_cmd_decoder #(.SR_W(SR_W), .IR_W(IR_W), .N_CH(N_CH), .DEPTH(DEPTH), .SYNC_STAGES(2))
      dut0 (.clk(clk), .reset(reset), .bus(bus0));
   dbg_slave_cmd_decoder #(.SR_W(SR_W), .IR_W(IR_W), .N_CH(3), .DEPTH(DEPTH), .SYNC_STAGES(2))
      dut1 (.clk(clk), .reset(reset), .bus(bus1));

   ent_t sb[$];
   int   errors    = 0;
   int   checks    = 0;
   int   pulses0   = 0;
   int   bad1_seen = 0;
   bit   pulse_now;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [SR_W-1:0] fix_par(input logic [SR_W-1:0] v);
      logic [SR_W-1:0] r;
      r = v;
`ifdef DBG_SLAVE_CMD_PARITY_EN
      if (^r) r[SR_W-2] = ~r[SR_W-2];
`endif
      return r;
   endfunction

   // Advance one clock, sample 1 time unit later and score any pulse.
   task automatic step();
      ent_t            e;
      logic [N_CH-1:0] ta;
      logic [N_CH-1:0] tna;
      logic [2:0]      ta3;
      logic [2:0]      tna3;
      logic            bad3;
      @(posedge clk);
      #1;
      pulse_now = (|bus0.take_action) || (|bus0.take_no_action) || bus0.bad_ir;
      if (pulse_now) begin
         pulses0++;
         check("pulse_has_entry", 64'(sb.size() != 0), 64'd1);
         if (sb.size() != 0) begin
            e    = sb.pop_front();
            ta   = e.sr[SR_W-1] ? N_CH'(1 << e.ir) : '0;
            tna  = e.sr[SR_W-1] ? '0 : N_CH'(1 << e.ir);
            bad3 = (e.ir == 2'd3);
            ta3  = bad3 ? 3'b000 : ta[2:0];
            tna3 = bad3 ? 3'b000 : tna[2:0];
            $display("pop ir=%0d jdo=%h ta=%b tna=%b bad1=%b", bus0.cmd_ir, bus0.jdo,
                     bus0.take_action, bus0.take_no_action, bus1.bad_ir);
            check("jdo", bus0.jdo, e.sr);
            check("cmd_ir", bus0.cmd_ir, e.ir);
            check("take_action", bus0.take_action, ta);
            check("take_no_action", bus0.take_no_action, tna);
            check("bad_ir", bus0.bad_ir, 1'b0);
            check("n3_take_action", bus1.take_action, ta3);
            check("n3_take_no_action", bus1.take_no_action, tna3);
            check("n3_bad_ir", bus1.bad_ir, bad3);
            if (bus1.bad_ir) bad1_seen++;
         end
      end else begin
         check("n3_quiet", 64'((|bus1.take_action) || (|bus1.take_no_action) || bus1.bad_ir), 64'd0);
      end
   endtask

   task automatic udr_pulse(input logic [IR_W-1:0] ir, input logic [SR_W-1:0] v, input bit accept);
      ent_t e;
      bus0.ir_in  = ir;
      bus0.sr     = v;
      bus0.vs_udr = 1'b1;
      if (accept) begin
         e.ir = ir;
         e.sr = v;
         sb.push_back(e);
      end
      repeat (3) step();
      bus0.vs_udr = 1'b0;
      repeat (3) step();
   endtask

   initial begin
      ent_t            e;
      logic [SR_W-1:0] v;
      logic [5:0]      pv;
      int              base;

      bus0.sr        = '0;
      bus0.ir_in     = '0;
      bus0.vs_udr    = 1'b0;
      bus0.vs_uir    = 1'b0;
      bus0.cmd_ready = 1'b0;
      bus0.ovf_clr   = 1'b0;
      reset          = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_cmd_valid", bus0.cmd_valid, 1'b0);
      check("rst_jdo", bus0.jdo, 0);
      check("rst_cmd_ir", bus0.cmd_ir, 0);
      check("rst_cur_ir", bus0.cur_ir, 0);
      check("rst_take_action", bus0.take_action, 0);
      check("rst_take_no_action", bus0.take_no_action, 0);
      check("rst_bad_ir", bus0.bad_ir, 0);
      check("rst_ovf", bus0.ovf_sticky, 0);
      check("rst_level", bus0.fifo_level, 0);
      check("rst_parity_err", bus0.parity_err, 0);
      reset = 1'b0;
      repeat (4) step();

      // Single command: latency from vs_udr rise to the action pulse.
      v              = fix_par(38'h20_0000_1234);
      bus0.ir_in     = 2'd2;
      bus0.sr        = v;
      bus0.cmd_ready = 1'b1;
      bus0.vs_udr    = 1'b1;
      e.ir = 2'd2;
      e.sr = v;
      sb.push_back(e);
      step();
      step();
      check("lat_valid_c2", bus0.cmd_valid, 1'b0);
      step();
      check("lat_level_c3", bus0.fifo_level, 1);
      check("lat_valid_c3", bus0.cmd_valid, 1'b0);
      bus0.vs_udr = 1'b0;
      step();
      check("lat_valid_c4", bus0.cmd_valid, 1'b1);
      step();
      check("lat_take_action_c5", bus0.take_action, 4'b0100);
      check("lat_jdo_c5", bus0.jdo, v);
      step();
      check("take_action_one_cycle", bus0.take_action, 4'b0000);
      check("valid_after_pop", bus0.cmd_valid, 1'b0);
      repeat (2) step();

      // No-action command on channel 1.
      udr_pulse(2'd1, fix_par(38'h00_0000_5678), 1'b1);
      check("pulses_after_two", pulses0, 2);

      // Fill with consumer stalled; the fifth command overflows.
      bus0.cmd_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         udr_pulse(IR_W'(i), fix_par({i[0], 37'(32'h1000 + i)}), i < 4);
      end
      check("full_level", bus0.fifo_level, 4);
      check("full_ovf", bus0.ovf_sticky, 1'b1);
      check("full_valid", bus0.cmd_valid, 1'b1);
      bus0.cmd_ready = 1'b1;
      pv = '0;
      for (int k = 0; k < 6; k++) begin
         step();
         pv[k] = pulse_now;
      end
      check("drain_back_to_back", pv, 6'b001111);
      check("drain_valid", bus0.cmd_valid, 1'b0);
      check("drain_level", bus0.fifo_level, 0);
      check("ovf_held", bus0.ovf_sticky, 1'b1);
      bus0.ovf_clr = 1'b1;
      step();
      bus0.ovf_clr = 1'b0;
      check("ovf_cleared", bus0.ovf_sticky, 1'b0);

      // Push into a full FIFO in the same cycle as a pop.
      bus0.cmd_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         udr_pulse(IR_W'(3 - i), fix_par({~i[0], 37'(32'h2000 + i)}), 1'b1);
      end
      check("refill_level", bus0.fifo_level, 4);
      v           = fix_par(38'h3F_FFFF_0000);
      bus0.ir_in  = 2'd3;
      bus0.sr     = v;
      bus0.vs_udr = 1'b1;
      e.ir = 2'd3;
      e.sr = v;
      sb.push_back(e);
      step();
      step();
      bus0.cmd_ready = 1'b1;
      step();
      bus0.cmd_ready = 1'b0;
      bus0.vs_udr    = 1'b0;
      check("pushpop_level", bus0.fifo_level, 4);
      check("pushpop_no_ovf", bus0.ovf_sticky, 1'b0);
      repeat (3) step();
      bus0.cmd_ready = 1'b1;
      repeat (6) step();
      check("pushpop_drained", bus0.fifo_level, 0);
      check("pushpop_sb_empty", sb.size(), 0);

      // Update-IR and out-of-range IR on the three-channel instance.
      bus0.ir_in  = 2'd3;
      bus0.vs_uir = 1'b1;
      repeat (3) step();
      check("cur_ir", bus0.cur_ir, 2'd3);
      check("uir_no_push", bus0.fifo_level, 0);
      bus0.vs_uir = 1'b0;
      repeat (3) step();
      base = bad1_seen;
      udr_pulse(2'd3, fix_par(38'h20_0000_00AA), 1'b1);
      check("bad_ir_seen_1", bad1_seen, base + 1);
      udr_pulse(2'd3, fix_par(38'h00_0000_0055), 1'b1);
      check("bad_ir_seen_2", bad1_seen, base + 2);
      udr_pulse(2'd1, fix_par(38'h00_0000_0077), 1'b1);
      check("cur_ir_kept", bus0.cur_ir, 2'd3);

      // Reset mid-operation with vs_udr high through release.
      bus0.cmd_ready = 1'b0;
      udr_pulse(2'd0, fix_par(38'h20_0000_0011), 1'b1);
      udr_pulse(2'd2, fix_par(38'h00_0000_0022), 1'b1);
      check("pre_reset_level", bus0.fifo_level, 2);
      base        = pulses0;
      bus0.vs_udr = 1'b1;
      reset       = 1'b1;
      sb.delete();
      #1;
      check("reset_level", bus0.fifo_level, 0);
      check("reset_valid", bus0.cmd_valid, 1'b0);
      repeat (2) step();
      reset          = 1'b0;
      bus0.cmd_ready = 1'b1;
      repeat (10) step();
      check("post_reset_level", bus0.fifo_level, 0);
      check("post_reset_valid", bus0.cmd_valid, 1'b0);
      check("post_reset_no_pulse", pulses0, base);
      bus0.vs_udr = 1'b0;
      repeat (3) step();
      udr_pulse(2'd0, fix_par(38'h20_0000_0001), 1'b1);
      check("post_reset_push_ok", pulses0, base + 1);

      // Odd-parity command.
      v = 38'h00_0000_0001;
`ifdef DBG_SLAVE_CMD_PARITY_EN
      udr_pulse(2'd0, v, 1'b0);
      check("parity_err_set", bus0.parity_err, 1'b1);
      check("parity_level", bus0.fifo_level, 0);
      check("parity_no_ovf", bus0.ovf_sticky, 1'b0);
      check("parity_no_pulse", pulses0, base + 1);
      bus0.ovf_clr = 1'b1;
      step();
      bus0.ovf_clr = 1'b0;
      check("parity_err_clr", bus0.parity_err, 1'b0);
`else
      udr_pulse(2'd0, v, 1'b1);
      check("parity_err_tied", bus0.parity_err, 1'b0);
      check("odd_parity_accepted", pulses0, base + 2);
`endif
      repeat (2) step();
      check("final_sb_empty", sb.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/dbg_slave_cmd_decoder.md
Name: dbg_slave_cmd_decoder

Overview:
Sysclk-side command decoder for the virtual-JTAG debug slave, and the parametrised successor of the fixed 38-bit, 2-bit-IR sysclk action block. It synchronises the tck-domain update strobes and captures the shifted register with its IR. It buffers captured commands in a small FIFO and, on a valid/ready handshake, emits one-cycle take_action / take_no_action pulses per IR channel. It sits between the tck shift logic and the CPU OCI/break/trace controllers.

Parameters:
SR_W, 38, width of shifted data register sr and of jdo
IR_W, 2, width of JTAG IR
N_CH, 4, number of decoded IR channels (N_CH <= 2**IR_W)
DEPTH, 4, command FIFO depth (power of 2, >= 2)
SYNC_STAGES, 2, synchroniser flops on vs_udr / vs_uir (>= 2)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-high reset
sr  in  SR_W  shifted data from tck domain; stable while vs_udr high
ir_in  in  IR_W  current IR from tck domain; stable while vs_udr/vs_uir high
vs_udr  in  1  update-DR level, tck domain
vs_uir  in  1  update-IR level, tck domain
cmd_ready  in  1  consumer can accept a command
ovf_clr  in  1  clears ovf_sticky (and parity_err when compiled in)
cmd_valid  out  1  FIFO non-empty
jdo  out  SR_W  data of last popped command
cmd_ir  out  IR_W  IR of last popped command
cur_ir  out  IR_W  IR latched on last update-IR
take_action  out  N_CH  one-hot pulse, action bit set
take_no_action  out  N_CH  one-hot pulse, action bit clear
bad_ir  out  1  pulse: popped IR >= N_CH
ovf_sticky  out  1  command dropped, FIFO full
fifo_level  out  $clog2(DEPTH+1)  occupancy
parity_err  out  1  sticky parity failure (0 without feature)

Behaviour:
- Reset values: all outputs 0; FIFO empty; sync chains 0; edge-detect previous-sample registers reset to 1, so a level already high at reset release is not an edge.
- Sync: vs_udr and vs_uir each pass through SYNC_STAGES flops. A rising edge is the sync output going 1 while the previous sample is 0.
- udr edge, cycle E: push {ir_in, sr} if not full. If full and no pop in cycle E: drop, set ovf_sticky.
- Full with a pop in the same cycle: push accepted.
- ovf_clr clears ovf_sticky. A drop in the same cycle takes priority (flag stays 1).
- uir edge: cur_ir <= ir_in next cycle. No FIFO effect.
- cmd_valid = (level != 0). It is registered, so it is high from cycle E+1 after a push into an empty FIFO.
- Pop occurs on cmd_valid && cmd_ready. On the following edge: jdo, cmd_ir <= head entry; level decrements.
- Pulses: one cycle after the pop, exactly one bit of take_action or take_no_action is high for exactly one cycle:
  - index = popped IR;
  - take_action if popped sr[SR_W-1]=1, else take_no_action.
- If popped IR >= N_CH: no take_* bit; bad_ir pulses instead.
- Back-to-back pops with cmd_ready held high give pulses on consecutive cycles.
- Latency with SYNC_STAGES=2 and cmd_ready=1, from the vs_udr rise at input cycle 0:
  - push at cycle 3;
  - cmd_valid at 4;
  - pop at 4;
  - jdo valid and pulse at 5.
- Level arithmetic: +1 push, -1 pop, 0 if both. Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- Reset mid-operation clears the FIFO and any pending pulse. A udr edge in flight in the sync chain is lost.

Optional Feature:
- Macro DBG_SLAVE_CMD_PARITY_EN.
- Enabled: on push, XOR over sr[SR_W-1:0] must be 0 (even parity; the tck side sets the parity bit at sr[SR_W-2]).
  - On failure the command is not pushed and parity_err is set sticky.
  - ovf_clr clears parity_err.
  - Parity is checked before the full check; a parity-failed command never sets ovf_sticky.
- Disabled: no check; parity_err tied 0.

Test Plan:
- Reset, then single udr pulse with ir_in=2, sr=38'h20_0000_1234, cmd_ready=1 -> cycle 5: jdo=38'h20_0000_1234, cmd_ir=2, take_action=4'b0100, and it is high for 1 cycle.
- Same with sr[37]=0, ir_in=1 -> take_no_action=4'b0010 only; take_action stays 0.
- cmd_ready=0, 5 udr pulses with DEPTH=4 -> fifo_level=4, ovf_sticky=1. Raise cmd_ready -> 4 pulses on consecutive cycles, in order; then cmd_valid=0. ovf_clr -> ovf_sticky=0.
- Push into a full FIFO in the same cycle as a pop -> no overflow; level stays 4.
- vs_uir pulse with ir_in=3 -> cur_ir=3. N_CH=3 and a popped command with IR=3 -> bad_ir pulses; take_* stays 0.
- Assert reset with 2 entries queued and vs_udr held high through release -> level=0, no pulse, no push after release. With DBG_SLAVE_CMD_PARITY_EN, odd-parity sr -> parity_err=1 and level unchanged.
